mux_scan_sequencer: RTL and testbench

Sequencer that drives the two select lines (x, y) of the 4:1 selector `circuit` and captures its single-bit output `o` for each channel in turn. On a start request it scans all four channels and assembles a 4-bit snapshot word. It delivers the word downstream over a valid/ready handshake. It sits directly around the selector: upstream of its select inputs and downstream of its output.

---
 rtl/mux_scan_sequencer.sv | 70 +++++++
 tb/tb_mux_scan_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the 4:1 selector's select lines, captures each channel and hands off a 4-bit snapshot.
module mux_scan_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
);
  localparam int CW = $clog2(SETTLE) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
  state_t     r_state;
  logic [1:0] r_ch;
  logic [CW-1:0] r_cnt;
  logic       r_x, r_y, r_busy, r_valid;
  logic [3:0] r_data;
  logic       w_last;
  logic [1:0] w_nch;
  assign w_last = r_cnt == CW'(SETTLE - 1);
  assign w_nch  = r_ch + 2'd1;
  assign {x, y, busy, valid, data} = {r_x, r_y, r_busy, r_valid, r_data};
  // w_nch wraps to 0 after channel 3, so the select returns to 00 on entering OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SCAN;
          r_ch    <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        SCAN: if (w_last) begin
          r_data[r_ch] <= o;
          r_cnt        <= '0;
          r_ch         <= w_nch;
          {r_x, r_y}   <= w_nch;
          if (r_ch == 2'd3) begin
            r_state <= OUT;
            r_valid <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        OUT: if (ready) begin
          r_valid <= 1'b0;
          r_ch    <= '0;
          r_cnt   <= '0;
          r_busy  <= start;
          r_state <= start ? SCAN : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: two sequencers (SETTLE=1 and SETTLE=3) around selector models, checked against a timeline model.
module tb_mux_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start[2], ready[2], o[2], x[2], y[2], busy[2], valid[2];
  logic [3:0] data[2], abcd[2];
  int         sv[2] = '{1, 3};
  bit         m_act[2] = '{0, 0}, m_val[2] = '{0, 0};
  int         m_t[2] = '{0, 0};
  logic [3:0] m_d[2] = '{4'h0, 4'h0};
  int         n_cmp = 0, n_bad = 0;
  int         lat, nv, first, np, i;
  logic [3:0] vd[2];
  int         vi[2];

  always #5 clk = ~clk;

  assign o[0] = abcd[0][{x[0], y[0]}];
  assign o[1] = abcd[1][{x[1], y[1]}];

  mux_scan_sequencer #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start[0]), .o(o[0]), .x(x[0]), .y(y[0]),
    .busy(busy[0]), .data(data[0]), .valid(valid[0]), .ready(ready[0]));
  mux_scan_sequencer #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start[1]), .o(o[1]), .x(x[1]), .y(y[1]),
    .busy(busy[1]), .data(data[1]), .valid(valid[1]), .ready(ready[1]));

  task automatic cmp(input string nm, input int n, input logic [3:0] a, input logic [3:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[inst %0d] at %0t: got %b, expected %b", nm, n, $time, a, e);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: m_t counts cycles since the scan began; channel k is shown while m_t/SETTLE==k.
  initial forever begin
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      cmp("sel", n, 4'({x[n], y[n]}), 4'(m_act[n] ? m_t[n] / sv[n] : 0));
      cmp("busy", n, 4'(busy[n]), 4'(m_act[n] | m_val[n]));
      cmp("valid", n, 4'(valid[n]), 4'(m_val[n]));
      if (m_val[n]) cmp("data", n, data[n], m_d[n]);
    end
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_act[n] = 0; m_val[n] = 0; m_t[n] = 0; m_d[n] = 4'h0;
      end else if (m_val[n]) begin
        if (ready[n]) begin
          m_val[n] = 0; m_act[n] = start[n]; m_t[n] = 0;
        end
      end else if (m_act[n]) begin
        if ((m_t[n] + 1) % sv[n] == 0) m_d[n][m_t[n] / sv[n]] = abcd[n][m_t[n] / sv[n]];
        if (m_t[n] + 1 == 4 * sv[n]) begin
          m_act[n] = 0; m_val[n] = 1;
        end
        m_t[n]++;
      end else if (start[n]) begin
        m_act[n] = 1; m_t[n] = 0;
      end
    end
  end

  task automatic wait_valid(input int n, input int lim, output int c);
    c = 1;
    while (valid[n] !== 1'b1 && c < lim) begin
      cyc(1);
      c++;
    end
    if (c >= lim) cmp("valid_timeout", n, 4'(valid[n]), 4'h1);
  endtask

  initial begin
    start = '{1'b1, 1'b1};
    ready = '{1'b0, 1'b0};
    abcd  = '{4'hF, 4'hF};
    cyc(2);
    rst = 1'b0;
    start = '{1'b0, 1'b0};
    for (int n = 0; n < 2; n++) begin
      cmp("rst_xy", n, 4'({x[n], y[n]}), 4'h0);
      cmp("rst_busy", n, 4'(busy[n]), 4'h0);
      cmp("rst_valid", n, 4'(valid[n]), 4'h0);
      cmp("rst_data", n, data[n], 4'h0);
    end
    cyc(3);
    cmp("idle_busy", 0, 4'(busy[0]), 4'h0);

    abcd[0] = 4'b1101; ready[0] = 1'b1; start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    wait_valid(0, 30, lat);
    cmp("basic_lat", 0, 4'(lat), 4'd5);
    cmp("basic_data", 0, data[0], 4'b1101);
    cyc(1);
    cmp("basic_busy_fall", 0, 4'(busy[0]), 4'h0);
    cyc(2);

    abcd[0] = 4'b0110; ready[0] = 1'b0; start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    wait_valid(0, 30, lat);
    abcd[0] = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      cmp("bp_valid", 0, 4'(valid[0]), 4'h1);
      cmp("bp_data", 0, data[0], 4'b0110);
      cyc(1);
    end
    ready[0] = 1'b1;
    cyc(1);
    cmp("bp_valid_drop", 0, 4'(valid[0]), 4'h0);
    cyc(2);

    abcd[1] = 4'b1010; ready[1] = 1'b1; start[1] = 1'b1;
    cyc(1);
    nv = 0; first = 0;
    for (int k = 1; k <= 30; k++) begin
      start[1] = (k == 5);
      if (valid[1] === 1'b1) begin
        nv++;
        if (first == 0) first = k;
      end
      cyc(1);
    end
    start[1] = 1'b0;
    cmp("s3_lat", 1, 4'(first), 4'd13);
    cmp("s3_count", 1, 4'(nv), 4'd1);
    cmp("s3_idle", 1, 4'(busy[1]), 4'h0);

    abcd[0] = 4'hF; ready[0] = 1'b1; start[0] = 1'b1;
    cyc(1);
    i = 1; np = 0;
    while (np < 2 && i < 40) begin
      if (valid[0] === 1'b1) begin
        vd[np] = data[0];
        vi[np] = i;
        np++;
        if (np == 1) abcd[0] = 4'h0;
        else start[0] = 1'b0;
      end
      cyc(1);
      i++;
    end
    start[0] = 1'b0;
    cmp("b2b_pulses", 0, 4'(np), 4'd2);
    cmp("b2b_first", 0, vd[0], 4'hF);
    cmp("b2b_second", 0, vd[1], 4'h0);
    cmp("b2b_spacing", 0, 4'(vi[1] - vi[0]), 4'd5);
    cyc(2);

    abcd[0] = 4'b0101; start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    i = 0;
    while ({x[0], y[0]} !== 2'b10 && i < 10) begin
      cyc(1);
      i++;
    end
    cmp("mid_sel", 0, 4'({x[0], y[0]}), 4'b0010);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cmp("mid_xy", 0, 4'({x[0], y[0]}), 4'h0);
    cmp("mid_busy", 0, 4'(busy[0]), 4'h0);
    cmp("mid_valid", 0, 4'(valid[0]), 4'h0);
    cmp("mid_data", 0, data[0], 4'h0);
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid[0] === 1'b1) nv++;
      cyc(1);
    end
    cmp("mid_no_snap", 0, 4'(nv), 4'h0);
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    wait_valid(0, 30, lat);
    cmp("fresh_lat", 0, 4'(lat), 4'd5);
    cmp("fresh_data", 0, data[0], 4'b0101);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
